// File: rtl/shift_add_mult_ctrl_if.sv
// Control bundle between the shift-add multiplier sequencer and its neighbours:
// requester side (start/abort/busy/done) and product-register side (q0/load/add_shift/shift).
interface shift_add_mult_ctrl_if;
  logic start;
  logic abort;
  logic q0;
  logic load;
  logic add_shift;
  logic shift;
  logic busy;
  logic done;

  // requester + datapath view
  modport master (
    output start, abort, q0,
    input  load, add_shift, shift, busy, done
  );

  // sequencer view
  modport slave (
    input  start, abort, q0,
    output load, add_shift, shift, busy, done
  );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for an N-bit shift-add multiplier: LOAD, N add/shift iterations, DONE pulse.
// Optional perf counters (op_count, add_count) are built when MULT_CTRL_PERF_EN is defined.
module shift_add_mult_ctrl #(
  parameter int N = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  shift_add_mult_ctrl_if.slave mif
`ifdef MULT_CTRL_PERF_EN
  ,
  output logic [15:0]          op_count,
  output logic [15:0]          add_count
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            load_d, add_d, shift_d, busy_d, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_d    = 1'b0;
    add_d     = 1'b0;
    shift_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (mif.start && !mif.abort) state_nxt = LOAD;
      end
      LOAD: begin
        load_d    = 1'b1;
        busy_d    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = mif.abort ? IDLE : RUN;
      end
      RUN: begin
        // q0 picks add-then-shift vs plain shift; exactly one is always asserted
        busy_d  = 1'b1;
        add_d   = mif.q0;
        shift_d = !mif.q0;
        cnt_nxt = cnt + CW'(1);
        if (mif.abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(N - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // reset forces the controls quiet in the cycle it is asserted, not just after the edge
  assign mif.load      = load_d  & ~reset;
  assign mif.add_shift = add_d   & ~reset;
  assign mif.shift     = shift_d & ~reset;
  assign mif.busy      = busy_d  & ~reset;
  assign mif.done      = done_d  & ~reset;

`ifdef MULT_CTRL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      op_count  <= '0;
      add_count <= '0;
    end else begin
      if (done_d) op_count  <= op_count + 16'd1;
      if (add_d)  add_count <= add_count + 16'd1;
    end
  end
`endif

endmodule
